// File: rtl/dit4_combine_round.sv
// Radix-4 DIT butterfly combine stage: sum/difference legs,
// round Q.SHIFT back to integer scale, saturate, tag group.
module dit4_combine_round #(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int OUT_WIDTH  = 23,
  parameter int GROUPS     = 4,
  localparam int PW = DATA_WIDTH + TWID_WIDTH + 1,
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [PW-1:0]        a0_r,
  input  logic signed [PW-1:0]        a1_r,
  input  logic signed [PW-1:0]        a2_r,
  input  logic signed [PW-1:0]        a3_r,
  input  logic signed [PW-1:0]        a0_i,
  input  logic signed [PW-1:0]        a1_i,
  input  logic signed [PW-1:0]        a2_i,
  input  logic signed [PW-1:0]        a3_i,
  input  logic                        sat_clr,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] y0_r,
  output logic signed [OUT_WIDTH-1:0] y1_r,
  output logic signed [OUT_WIDTH-1:0] y2_r,
  output logic signed [OUT_WIDTH-1:0] y3_r,
  output logic signed [OUT_WIDTH-1:0] y0_i,
  output logic signed [OUT_WIDTH-1:0] y1_i,
  output logic signed [OUT_WIDTH-1:0] y2_i,
  output logic signed [OUT_WIDTH-1:0] y3_i,
  output logic [GW-1:0]               grp_idx,
  output logic                        grp_last,
  output logic                        sat_flag
);

  localparam int TW = PW + 1;
  localparam int VW = PW + 2;
  localparam int SW = PW + 3;
  localparam int RW = SW - SHIFT;

  localparam logic signed [SW-1:0] HALF =
    SW'(2 ** (SHIFT - 1));
  localparam logic signed [RW-1:0] MAXV =
    RW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [RW-1:0] MINV =
    RW'(-(2 ** (OUT_WIDTH - 1)));
  localparam logic [GW-1:0] LAST = GW'(GROUPS - 1);

  // {clip, value}: round half toward +inf, then clamp
  function automatic logic [OUT_WIDTH:0] rnd_sat(
    input logic signed [VW-1:0] v
  );
    logic signed [SW-1:0] s;
    logic signed [RW-1:0] r;
    s = SW'(v) + HALF;
    r = RW'(s >>> SHIFT);
    if (r > MAXV)
      return {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (r < MINV)
      return {1'b1, MINV[OUT_WIDTH-1:0]};
    else
      return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  logic signed [PW-1:0] ar [4];
  logic signed [PW-1:0] ai [4];

  assign ar[0] = a0_r;
  assign ar[1] = a1_r;
  assign ar[2] = a2_r;
  assign ar[3] = a3_r;
  assign ai[0] = a0_i;
  assign ai[1] = a1_i;
  assign ai[2] = a2_i;
  assign ai[3] = a3_i;

  logic signed [TW-1:0] t_r_d [4];
  logic signed [TW-1:0] t_i_d [4];
  logic signed [TW-1:0] t_r_q [4];
  logic signed [TW-1:0] t_i_q [4];
  logic                 v1_q;

  // S1: radix-2 pairs (a0,a2) and (a1,a3)
  always_comb begin
    t_r_d[0] = TW'(ar[0]) + TW'(ar[2]);
    t_i_d[0] = TW'(ai[0]) + TW'(ai[2]);
    t_r_d[1] = TW'(ar[0]) - TW'(ar[2]);
    t_i_d[1] = TW'(ai[0]) - TW'(ai[2]);
    t_r_d[2] = TW'(ar[1]) + TW'(ar[3]);
    t_i_d[2] = TW'(ai[1]) + TW'(ai[3]);
    t_r_d[3] = TW'(ar[1]) - TW'(ar[3]);
    t_i_d[3] = TW'(ai[1]) - TW'(ai[3]);
  end

  // S1 register: data loads every cycle, valid follows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      t_r_q <= '{default: '0};
      t_i_q <= '{default: '0};
    end else begin
      v1_q  <= in_valid;
      t_r_q <= t_r_d;
      t_i_q <= t_i_d;
    end
  end

  logic signed [VW-1:0] v_r_d [4];
  logic signed [VW-1:0] v_i_d [4];
  logic signed [VW-1:0] v_r_q [4];
  logic signed [VW-1:0] v_i_q [4];
  logic                 v2_q;

  // S2: second radix-2 layer, -j / +j rotation on t3
  always_comb begin
    v_r_d[0] = VW'(t_r_q[0]) + VW'(t_r_q[2]);
    v_i_d[0] = VW'(t_i_q[0]) + VW'(t_i_q[2]);
    v_r_d[2] = VW'(t_r_q[0]) - VW'(t_r_q[2]);
    v_i_d[2] = VW'(t_i_q[0]) - VW'(t_i_q[2]);
    v_r_d[1] = VW'(t_r_q[1]) + VW'(t_i_q[3]);
    v_i_d[1] = VW'(t_i_q[1]) - VW'(t_r_q[3]);
    v_r_d[3] = VW'(t_r_q[1]) - VW'(t_i_q[3]);
    v_i_d[3] = VW'(t_i_q[1]) + VW'(t_r_q[3]);
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      v_r_q <= '{default: '0};
      v_i_q <= '{default: '0};
    end else begin
      v2_q  <= v1_q;
      v_r_q <= v_r_d;
      v_i_q <= v_i_d;
    end
  end

  logic signed [OUT_WIDTH-1:0] y_r_d [4];
  logic signed [OUT_WIDTH-1:0] y_i_d [4];
  logic signed [OUT_WIDTH-1:0] y_r_q [4];
  logic signed [OUT_WIDTH-1:0] y_i_q [4];
  logic                        clip_any;
  logic                        ov_q;
  logic                        sat_d;
  logic                        sat_q;

  // S3: round/saturate all eight components, collect clips
  always_comb begin
    logic [OUT_WIDTH:0] pr;
    logic [OUT_WIDTH:0] pi;
    clip_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pr = rnd_sat(v_r_q[k]);
      pi = rnd_sat(v_i_q[k]);
      y_r_d[k] = pr[OUT_WIDTH-1:0];
      y_i_d[k] = pi[OUT_WIDTH-1:0];
      clip_any = clip_any | pr[OUT_WIDTH] | pi[OUT_WIDTH];
    end
  end

  // Sticky saturation: a clip on the same edge beats clear
  always_comb begin
    sat_d = sat_q;
    if (sat_clr)
      sat_d = 1'b0;
    if (v2_q && clip_any)
      sat_d = 1'b1;
  end

  // S3 register: outputs load only on valid, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      sat_q <= 1'b0;
      y_r_q <= '{default: '0};
      y_i_q <= '{default: '0};
    end else begin
      ov_q  <= v2_q;
      sat_q <= sat_d;
      if (v2_q) begin
        y_r_q <= y_r_d;
        y_i_q <= y_i_d;
      end
    end
  end

  logic [GW-1:0] cnt_d;
  logic [GW-1:0] cnt_q;

  // Group counter advances past each presented beat
  always_comb begin
    cnt_d = cnt_q;
    if (ov_q)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + GW'(1);
  end

  // Group counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign out_valid = ov_q;
  assign grp_idx   = cnt_q;
  assign grp_last  = ov_q && (cnt_q == LAST);
  assign sat_flag  = sat_q;

  assign y0_r = y_r_q[0];
  assign y1_r = y_r_q[1];
  assign y2_r = y_r_q[2];
  assign y3_r = y_r_q[3];
  assign y0_i = y_i_q[0];
  assign y1_i = y_i_q[1];
  assign y2_i = y_i_q[2];
  assign y3_i = y_i_q[3];

endmodule

// File: tb/tb_dit4_combine_round.sv
// Directed bench for dit4_combine_round: butterfly math,
// rounding, saturation, valid/group tagging and reset.
module tb_dit4_combine_round;

  localparam int PW = 38;
  localparam int OW = 23;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic sat_clr;
  logic signed [PW-1:0] ar [4];
  logic signed [PW-1:0] ai [4];
  logic out_valid;
  logic grp_last;
  logic sat_flag;
  logic [1:0] grp_idx;
  logic signed [OW-1:0] yr [4];
  logic signed [OW-1:0] yi [4];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dit4_combine_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a0_r      (ar[0]),
    .a1_r      (ar[1]),
    .a2_r      (ar[2]),
    .a3_r      (ar[3]),
    .a0_i      (ai[0]),
    .a1_i      (ai[1]),
    .a2_i      (ai[2]),
    .a3_i      (ai[3]),
    .sat_clr   (sat_clr),
    .out_valid (out_valid),
    .y0_r      (yr[0]),
    .y1_r      (yr[1]),
    .y2_r      (yr[2]),
    .y3_r      (yr[3]),
    .y0_i      (yi[0]),
    .y1_i      (yi[1]),
    .y2_i      (yi[2]),
    .y3_i      (yi[3]),
    .grp_idx   (grp_idx),
    .grp_last  (grp_last),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [PW-1:0] q(input longint v);
    return PW'(v * 32768);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ar[k] = '0;
      ai[k] = '0;
    end
  endtask

  // Send the legs already set as one sample; return when
  // its result is on the outputs. clr pulses sat_clr on
  // the edge that loads the result.
  task automatic run1(input bit clr);
    in_valid = 1'b1;
    step;
    idle;
    step;
    sat_clr = clr;
    step;
    sat_clr = 1'b0;
  endtask

  task automatic do_reset;
    idle;
    rst_n = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  bit pat [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    int beat;
    int stale;
    bit eov;

    rst_n = 1'b0;
    idle;
    step;
    step;
    check("rst_ov", out_valid, 0);
    check("rst_y0r", yr[0], 0);
    check("rst_y3i", yi[3], 0);
    check("rst_grp", grp_idx, 0);
    check("rst_last", grp_last, 0);
    check("rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    step;

    ar[0] = q(1000);
    run1(1'b0);
    check("t1_ov", out_valid, 1);
    check("t1_grp", grp_idx, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_y%0dr", k), yr[k], 1000);
      check($sformatf("t1_y%0di", k), yi[k], 0);
    end
    step;
    check("t1_bub_ov", out_valid, 0);
    check("t1_hold", yr[0], 1000);
    check("t1_grp1", grp_idx, 1);

    for (int k = 0; k < 4; k++) ar[k] = q(100);
    run1(1'b0);
    check("t2_y0r", yr[0], 400);
    check("t2_y1r", yr[1], 0);
    check("t2_y2r", yr[2], 0);
    check("t2_y3r", yr[3], 0);
    check("t2_sat", sat_flag, 0);

    ar[0] = PW'(16384);
    run1(1'b0);
    check("rnd_p_y0", yr[0], 1);
    check("rnd_p_y2", yr[2], 1);
    ar[0] = PW'(-16384);
    run1(1'b0);
    check("rnd_m_y0", yr[0], 0);
    check("rnd_m_y3", yr[3], 0);
    ar[0] = PW'(-16385);
    run1(1'b0);
    check("rnd_m1_y0", yr[0], -1);
    check("rnd_m1_y1", yr[1], -1);
    ai[1] = q(100);
    run1(1'b0);
    check("j_y0i", yi[0], 100);
    check("j_y1r", yr[1], 100);
    check("j_y1i", yi[1], 0);
    check("j_y2i", yi[2], -100);
    check("j_y3r", yr[3], -100);
    check("j_y3i", yi[3], 0);

    for (int k = 0; k < 4; k++) ar[k] = q(2097151);
    run1(1'b0);
    check("sat_pos_y0", yr[0], 4194303);
    check("sat_pos_y1", yr[1], 0);
    check("sat_set", sat_flag, 1);
    for (int k = 0; k < 4; k++) ar[k] = q(-2097152);
    run1(1'b0);
    check("sat_neg_y0", yr[0], -4194304);
    run1(1'b0);
    check("sat_sticky", sat_flag, 1);
    for (int k = 0; k < 4; k++) ar[k] = q(2097151);
    run1(1'b1);
    check("sat_setwins", sat_flag, 1);
    sat_clr = 1'b1;
    step;
    sat_clr = 1'b0;
    check("sat_clr", sat_flag, 0);

    do_reset;
    beat = 0;
    for (int k = 0; k < 13; k++) begin
      in_valid = (k < 9) ? pat[k] : 1'b0;
      ar[0] = q(k + 1);
      step;
      eov = (k >= 2 && k - 2 < 9) ? pat[k-2] : 1'b0;
      check($sformatf("bb_ov%0d", k), out_valid, eov);
      if (eov) begin
        check($sformatf("bb_grp%0d", beat), grp_idx, beat % 4);
        check($sformatf("bb_last%0d", beat), grp_last,
              (beat % 4 == 3) ? 1 : 0);
        check($sformatf("bb_y%0d", beat), yr[0], k - 1);
        beat++;
      end
    end
    idle;

    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      ar[0] = q(7);
      step;
    end
    idle;
    check("mr_pre_ov", out_valid, 1);
    check("mr_pre_grp", grp_idx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_ov", out_valid, 0);
    check("mr_y0r", yr[0], 0);
    check("mr_grp", grp_idx, 0);
    rst_n = 1'b1;
    stale = 0;
    repeat (5) begin
      step;
      if (out_valid) stale++;
    end
    check("mr_stale", stale, 0);
    ar[0] = q(5);
    run1(1'b0);
    check("mr_post_ov", out_valid, 1);
    check("mr_post_grp", grp_idx, 0);
    check("mr_post_y0", yr[0], 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
